// File: rtl/ltc_reader.sv
`timescale 1ns/1ps
// ltc_reader: decodes a biphase-mark SMPTE LTC stream into BCD timecode fields.
// Transition intervals are timed in clk cycles, classified as half or full
// cells, and decoded bits are shifted LSB-first into an 80-bit frame register.
// A sync word seen after a full frame of bits latches the fields.
module ltc_reader #(
    parameter int unsigned CLK_HZ = 10_000_000,
    parameter int unsigned T_MIN  = CLK_HZ / 12000,
    parameter int unsigned T_THR  = CLK_HZ / 3000,
    parameter int unsigned T_OUT  = CLK_HZ / 1000,
    parameter int unsigned CNT_W  = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ltc_in,
    output logic       locked,
    output logic       frame_valid,
    output logic       drop_frame,
    output logic [5:0] hours,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic [5:0] frames
);

    localparam logic [CNT_W-1:0] T_MIN_C    = CNT_W'(T_MIN);
    localparam logic [CNT_W-1:0] T_THR_C    = CNT_W'(T_THR);
    localparam logic [CNT_W-1:0] T_OUT_C    = CNT_W'(T_OUT);
    localparam logic [15:0]      SYNC_WORD  = 16'hBFFC;
    localparam logic [6:0]       FRAME_BITS = 7'd80;

    logic             sync1_r, sync2_r, prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic [79:0]      sr_r;
    logic [6:0]       bit_cnt_r;
    logic             half_pending_r;
    logic             lock_r;
    logic             accept_r;

    logic             edge_s;
    logic             emit_s;
    logic             bit_s;
    logic             error_s;
    logic             accept_s;
    logic             half_next_s;
    logic             lock_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [79:0]      sr_next_s;
    logic [6:0]       bit_cnt_next_s;

    // Synchronise ltc_in and keep the previous sample for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= ltc_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Classify each interval, decide emitted bits, errors and sync acceptance.
    always_comb begin
        edge_s         = sync2_r ^ prev_r;
        emit_s         = 1'b0;
        bit_s          = 1'b0;
        error_s        = 1'b0;
        accept_s       = 1'b0;
        half_next_s    = half_pending_r;
        lock_next_s    = lock_r;
        cnt_next_s     = cnt_r;
        sr_next_s      = sr_r;
        bit_cnt_next_s = bit_cnt_r;

        if (edge_s) begin
            cnt_next_s = {CNT_W{1'b0}};
            if (cnt_r == T_OUT_C) begin
                // First transition after silence only establishes phase.
                half_next_s = 1'b0;
            end else if (cnt_r < T_MIN_C) begin
                error_s = 1'b1;
            end else if (cnt_r < T_THR_C) begin
                if (half_pending_r) begin
                    emit_s      = 1'b1;
                    bit_s       = 1'b1;
                    half_next_s = 1'b0;
                end else begin
                    half_next_s = 1'b1;
                end
            end else begin
                if (half_pending_r) begin
                    // A full cell cannot follow an unpaired half cell.
                    error_s = 1'b1;
                end else begin
                    emit_s = 1'b1;
                    bit_s  = 1'b0;
                end
            end
        end else begin
            if (cnt_r == T_OUT_C) begin
                cnt_next_s = cnt_r;
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
                // Reaching the saturation value means the stream has gone quiet.
                if (cnt_r == T_OUT_C - CNT_W'(1)) begin
                    error_s = 1'b1;
                end else begin
                    error_s = 1'b0;
                end
            end
        end

        if (error_s) begin
            half_next_s    = 1'b0;
            bit_cnt_next_s = 7'd0;
            lock_next_s    = 1'b0;
        end else if (emit_s) begin
            sr_next_s      = {bit_s, sr_r[79:1]};
            bit_cnt_next_s = (bit_cnt_r == FRAME_BITS) ? FRAME_BITS : bit_cnt_r + 7'd1;
            if ((sr_next_s[79:64] == SYNC_WORD) && (bit_cnt_next_s >= FRAME_BITS)) begin
                accept_s       = 1'b1;
                bit_cnt_next_s = 7'd0;
                lock_next_s    = 1'b1;
            end else if ((bit_cnt_next_s == FRAME_BITS) && lock_r) begin
                // A whole frame went by without a sync word.
                lock_next_s = 1'b0;
            end else begin
                lock_next_s = lock_r;
            end
        end else begin
            sr_next_s = sr_r;
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r          <= T_OUT_C;
            sr_r           <= 80'd0;
            bit_cnt_r      <= 7'd0;
            half_pending_r <= 1'b0;
            lock_r         <= 1'b0;
            accept_r       <= 1'b0;
        end else begin
            cnt_r          <= cnt_next_s;
            sr_r           <= sr_next_s;
            bit_cnt_r      <= bit_cnt_next_s;
            half_pending_r <= half_next_s;
            lock_r         <= lock_next_s;
            accept_r       <= accept_s;
        end
    end

    // Registered outputs: fields latch whole from the frame register on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked      <= 1'b0;
            frame_valid <= 1'b0;
            drop_frame  <= 1'b0;
            hours       <= 6'd0;
            minutes     <= 7'd0;
            seconds     <= 7'd0;
            frames      <= 6'd0;
        end else begin
            locked      <= lock_r;
            frame_valid <= accept_r;
            if (accept_r) begin
                drop_frame <= sr_r[10];
                hours      <= {sr_r[57:56], sr_r[51:48]};
                minutes    <= {sr_r[42:40], sr_r[35:32]};
                seconds    <= {sr_r[26:24], sr_r[19:16]};
                frames     <= {sr_r[9:8],   sr_r[3:0]};
            end else begin
                drop_frame <= drop_frame;
                hours      <= hours;
                minutes    <= minutes;
                seconds    <= seconds;
                frames     <= frames;
            end
        end
    end

endmodule

// File: tb/tb_ltc_reader.sv
`timescale 1ns/1ps
// Directed bench for ltc_reader with a frame-level expectation model.
// Scaled clock rate keeps frames short: full cell 50 clk, half 25 at 25fps.
module tb_ltc_reader;

    localparam int unsigned CLK_HZ = 100_000;
    localparam int FULL25 = 50;
    localparam int HALF25 = 25;
    localparam int FULL30 = 42;
    localparam int HALF30 = 21;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ltc_in = 1'b0;
    logic       locked, frame_valid, drop_frame;
    logic [5:0] hours, frames;
    logic [6:0] minutes, seconds;

    typedef struct {
        time         t;
        logic [26:0] f;
    } exp_t;

    exp_t        exp_a [16];
    int          wr_idx = 0;
    int          rd_idx = 0;
    logic [26:0] m_fields = 27'd0;
    logic        mon_en = 1'b0;
    time         last_edge = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ltc_reader #(.CLK_HZ(CLK_HZ)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ltc_in      (ltc_in),
        .locked      (locked),
        .frame_valid (frame_valid),
        .drop_frame  (drop_frame),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .frames      (frames)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, req);
        end
    endtask

    // Expected field word {hours, minutes, seconds, frames, drop} from decimal values.
    function automatic logic [26:0] exp_fields(input int hh, input int mm, input int ss,
                                               input int ff, input logic df);
        return {6'((hh / 10) * 16 + hh % 10), 7'((mm / 10) * 16 + mm % 10),
                7'((ss / 10) * 16 + ss % 10), 6'((ff / 10) * 16 + ff % 10), df};
    endfunction

    // LTC frame bit layout, bit 0 transmitted first.
    function automatic logic [79:0] make_frame(input int hh, input int mm, input int ss,
                                               input int ff, input logic df);
        logic [79:0] w;
        w        = 80'd0;
        w[3:0]   = 4'(ff % 10);
        w[9:8]   = 2'(ff / 10);
        w[10]    = df;
        w[19:16] = 4'(ss % 10);
        w[26:24] = 3'(ss / 10);
        w[35:32] = 4'(mm % 10);
        w[42:40] = 3'(mm / 10);
        w[51:48] = 4'(hh % 10);
        w[57:56] = 2'(hh / 10);
        w[79:64] = 16'hBFFC;
        return w;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle();
        ltc_in    = ~ltc_in;
        last_edge = $time;
    endtask

    // Send nbits of a frame; the bit at glitch_at carries a short spike instead.
    task automatic send_frame(input int hh, input int mm, input int ss, input int ff,
                              input logic df, input int full, input int half,
                              input int nbits, input int skip, input int glitch_at,
                              input logic expect_ok);
        logic [79:0] w;
        w = make_frame(hh, mm, ss, ff, df);
        for (int i = 0; i < nbits; i++) begin
            int pre;
            pre = (i == 0) ? skip : 0;
            if (i == glitch_at) begin
                wait_clk(20 - pre); toggle();
                wait_clk(3);        toggle();
                wait_clk(full - 23); toggle();
            end else if (w[i]) begin
                wait_clk(half - pre); toggle();
                wait_clk(full - half); toggle();
            end else begin
                wait_clk(full - pre); toggle();
            end
        end
        if (expect_ok) begin
            // Closing edge + 3 clk sync/decode + 1 clk output register, sampled on negedge.
            exp_a[wr_idx].t = last_edge + 44;
            exp_a[wr_idx].f = exp_fields(hh, mm, ss, ff, df);
            wr_idx++;
        end
    endtask

    // Per-cycle comparison of pulse timing and held fields against the model.
    task automatic compare_cycle();
        logic pulse_due;
        pulse_due = 1'b0;
        if (!reset_n || !mon_en) begin
            rd_idx   = wr_idx;
            m_fields = 27'd0;
        end else begin
            while (rd_idx < wr_idx && exp_a[rd_idx].t < $time) begin
                checks++;
                errors++;
                $display("FAIL pulse_missing at %0t: frame_valid=0, required 1 at %0t",
                         $time, exp_a[rd_idx].t);
                rd_idx++;
            end
            if (rd_idx < wr_idx && exp_a[rd_idx].t == $time) begin
                pulse_due = 1'b1;
                m_fields  = exp_a[rd_idx].f;
                rd_idx++;
            end
            chk("frame_valid", 32'(frame_valid), 32'(pulse_due));
            chk("fields", 32'({hours, minutes, seconds, frames, drop_frame}), 32'(m_fields));
            if (pulse_due) begin
                chk("locked_at_pulse", 32'(locked), 32'd1);
            end
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        // Reset state.
        reset_n = 1'b0;
        ltc_in  = 1'b0;
        wait_clk(3);
        chk("reset_outputs", 32'({locked, frame_valid, drop_frame, hours, minutes, seconds, frames}), 32'd0);
        reset_n = 1'b1;
        wait_clk(5);
        mon_en = 1'b1;

        // Two consecutive 25fps frames 12:34:56:07.
        toggle();
        send_frame(12, 34, 56, 7, 1'b0, FULL25, HALF25, 80, 0, -1, 1'b1);
        send_frame(12, 34, 56, 7, 1'b0, FULL25, HALF25, 80, 0, -1, 1'b1);
        wait_clk(4);
        chk("pin_frame_valid", 32'(frame_valid), 32'd1);
        chk("pin_hours",   32'(hours),   32'h12);
        chk("pin_minutes", 32'(minutes), 32'h34);
        chk("pin_seconds", 32'(seconds), 32'h56);
        chk("pin_frames",  32'(frames),  32'h07);
        chk("pin_locked",  32'(locked),  32'd1);

        // Reset asserted halfway through the next frame.
        send_frame(12, 34, 56, 7, 1'b0, FULL25, HALF25, 40, 4, -1, 1'b0);
        chk("locked_before_reset", 32'(locked), 32'd1);
        reset_n = 1'b0;
        ltc_in  = 1'b0;
        #1;
        chk("reset_mid_stream", 32'({locked, frame_valid, drop_frame, hours, minutes, seconds, frames}), 32'd0);
        wait_clk(5);
        reset_n = 1'b1;
        wait_clk(5);

        // 30fps drop-frame 01:00:00:02.
        toggle();
        send_frame(1, 0, 0, 2, 1'b1, FULL30, HALF30, 80, 0, -1, 1'b1);
        wait_clk(4);
        chk("df_drop_frame", 32'(drop_frame), 32'd1);
        chk("df_frames",     32'(frames),     32'h02);
        chk("df_hours",      32'(hours),      32'h01);
        wait_clk(200);

        // Lock, then silence 150 clk: lock lost, fields held, then relock.
        toggle();
        send_frame(12, 34, 56, 7, 1'b0, FULL25, HALF25, 80, 0, -1, 1'b1);
        wait_clk(90);
        chk("locked_before_timeout", 32'(locked), 32'd1);
        wait_clk(15);
        chk("locked_after_timeout", 32'(locked), 32'd0);
        chk("hours_held", 32'(hours), 32'h12);
        wait_clk(45);
        toggle();
        send_frame(23, 59, 58, 24, 1'b0, FULL25, HALF25, 80, 0, -1, 1'b1);

        // Glitch mid-frame: this frame and its sync dropped, next frame accepted.
        send_frame(10, 20, 30, 15, 1'b0, FULL25, HALF25, 80, 0, 29, 1'b0);
        chk("locked_after_glitch", 32'(locked), 32'd0);
        send_frame(5, 6, 7, 8, 1'b0, FULL25, HALF25, 80, 0, -1, 1'b1);

        // Lone half cell followed by a full cell.
        wait_clk(HALF25);
        toggle();
        chk("locked_before_half_err", 32'(locked), 32'd1);
        wait_clk(FULL25);
        toggle();
        wait_clk(5);
        chk("locked_after_half_err", 32'(locked), 32'd0);
        chk("hours_after_half_err", 32'(hours), 32'h05);
        wait_clk(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
